// File: rtl/fp_norm_sequencer.sv
// Post-add normalization sequencer for the single-precision FP adder: carry shift, one-per-cycle cancellation shifts.
// Optional macro FTZ_EN flushes denormal results to zero and raises out_uf.
module fp_norm_sequencer #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [FRAC_W+1:0]   in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [EXP_W-1:0]    out_exp,
    output logic [FRAC_W-1:0]   out_frac,
    output logic                out_ovf,
    output logic                out_zero,
    output logic                out_uf
);
    localparam int unsigned MANT_W = FRAC_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CARRY  = 2'd1;
    localparam logic [1:0] S_SHIFTL = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state, state_n;
    logic              sign_q, sign_n;
    logic [EXP_W-1:0]  exp_q, exp_n, exp_eff;
    logic [MANT_W-1:0] mant_q, mant_n;
    logic              ovf_q, ovf_n, zero_q, zero_n, inf_q, inf_n;
    logic              load_out;
    logic [EXP_W-1:0]  pk_exp;
    logic [FRAC_W-1:0] pk_frac;
    logic              pk_ovf, pk_zero;

    // Controlled exponent incrementor used for carry-out renormalization
    function automatic logic [EXP_W-1:0] exp_inc(input logic en, input logic [EXP_W-1:0] a);
        return a + EXP_W'(en);
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign exp_eff   = (in_exp == '0) ? EXP_ONE : in_exp;

    // Next-state and datapath sequencing
    always_comb begin
        state_n = state;
        sign_n  = sign_q;
        exp_n   = exp_q;
        mant_n  = mant_q;
        ovf_n   = ovf_q;
        zero_n  = zero_q;
        inf_n   = inf_q;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    sign_n = in_sign;
                    mant_n = in_mant;
                    exp_n  = exp_eff;
                    ovf_n  = 1'b0;
                    zero_n = 1'b0;
                    inf_n  = 1'b0;
                    if (in_exp == EXP_MAX) begin
                        exp_n   = EXP_MAX;
                        inf_n   = 1'b1;
                        state_n = S_DONE;
                    end else if (in_mant == '0) begin
                        exp_n   = '0;
                        zero_n  = 1'b1;
                        state_n = S_DONE;
                    end else if (in_mant[MANT_W-1]) begin
                        state_n = S_CARRY;
                    end else if (in_mant[FRAC_W] || exp_eff == EXP_ONE) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_SHIFTL;
                    end
                end
            end
            S_CARRY: begin
                mant_n  = mant_q >> 1;
                exp_n   = exp_inc(1'b1, exp_q);
                ovf_n   = (exp_n == EXP_MAX);
                state_n = S_DONE;
            end
            S_SHIFTL: begin
                mant_n = mant_q << 1;
                exp_n  = exp_q - EXP_ONE;
                if (mant_n[FRAC_W] || exp_n == EXP_ONE) state_n = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign load_out = (state_n == S_DONE) && (state != S_DONE);

    // Result packing; special cases take priority over the denormal encoding
    always_comb begin
        pk_exp  = exp_n;
        pk_frac = mant_n[FRAC_W-1:0];
        pk_ovf  = 1'b0;
        pk_zero = 1'b0;
        if (inf_n) begin
            pk_exp = EXP_MAX;
        end else if (zero_n) begin
            pk_exp  = '0;
            pk_frac = '0;
            pk_zero = 1'b1;
        end else if (ovf_n) begin
            pk_exp  = EXP_MAX;
            pk_frac = '0;
            pk_ovf  = 1'b1;
        end else if (!mant_n[FRAC_W]) begin
            pk_exp = '0;
`ifdef FTZ_EN
            pk_frac = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_frac <= '0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            state  <= state_n;
            sign_q <= sign_n;
            exp_q  <= exp_n;
            mant_q <= mant_n;
            ovf_q  <= ovf_n;
            zero_q <= zero_n;
            inf_q  <= inf_n;
            if (load_out) begin
                out_sign <= sign_n;
                out_exp  <= pk_exp;
                out_frac <= pk_frac;
                out_ovf  <= pk_ovf;
                out_zero <= pk_zero;
            end
        end
    end

`ifdef FTZ_EN
    // Underflow flag marks a nonzero denormal that was flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_uf <= 1'b0;
        end else if (load_out) begin
            out_uf <= !inf_n && !zero_n && !ovf_n && !mant_n[FRAC_W];
        end
    end
`else
    assign out_uf = 1'b0;
`endif

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed vector bench for fp_norm_sequencer: latency, packing, flags, backpressure and mid-run reset.
module tb_fp_norm_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_ovf, out_zero, out_uf;

    int total = 0;
    int bad   = 0;

    fp_norm_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_ovf(out_ovf), .out_zero(out_zero), .out_uf(out_uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        int          lat;
        logic [7:0]  exp_o;
        logic [22:0] frac_o;
        logic        ovf;
        logic        zero;
        logic        uf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one operand, then count negedges until out_valid (bounded)
    task automatic apply(input logic s, input logic [7:0] e, input logic [24:0] m, output int lat);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[11];
    int   lat;
    int   seen;

    initial begin
        logic dn_uf;
        logic [22:0] dn6, dn8;
`ifdef FTZ_EN
        dn_uf = 1'b1; dn6 = 23'h0; dn8 = 23'h0;
`else
        dn_uf = 1'b0; dn6 = 23'h040000; dn8 = 23'h000005;
`endif
        vecs[0]  = '{1'b0, 8'h80, 25'h0800000,  1, 8'h80, 23'h000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h7F, 25'h1800000,  2, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h85, 25'h0000100, 16, 8'h76, 23'h000000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'hFE, 25'h1000000,  2, 8'hFF, 23'h000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h40, 25'h0000000,  1, 8'h00, 23'h000000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h03, 25'h0010000,  3, 8'h00, dn6,        1'b0, 1'b0, dn_uf};
        vecs[6]  = '{1'b0, 8'hFF, 25'h0400001,  1, 8'hFF, 23'h400001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 25'h0000005,  1, 8'h00, dn8,        1'b0, 1'b0, dn_uf};
        vecs[8]  = '{1'b1, 8'h10, 25'h0ABCDEF,  1, 8'h10, 23'h2BCDEF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h01, 25'h1FFFFFF,  2, 8'h02, 23'h7FFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 25'h1000001,  2, 8'h02, 23'h000000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_exp", 32'(out_exp), 32'd0);
        chk("rst_out_frac", 32'(out_frac), 32'd0);
        chk("rst_flags", 32'({out_sign, out_ovf, out_zero, out_uf}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].sign, vecs[i].exp, vecs[i].mant, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d_sign", i), 32'(out_sign), 32'(vecs[i].sign));
            chk($sformatf("v%0d_exp", i), 32'(out_exp), 32'(vecs[i].exp_o));
            chk($sformatf("v%0d_frac", i), 32'(out_frac), 32'(vecs[i].frac_o));
            chk($sformatf("v%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].zero));
            chk($sformatf("v%0d_uf", i), 32'(out_uf), 32'(vecs[i].uf));
            consume();
        end

        // Backpressure: result held while downstream stalls; new inputs ignored
        apply(1'b0, 8'h7F, 25'h1800000, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        in_valid = 1'b1; in_exp = 8'h11; in_mant = 25'h0800000; in_sign = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_exp", c), 32'(out_exp), 32'h80);
            chk($sformatf("bp%0d_frac", c), 32'(out_frac), 32'h400000);
            chk($sformatf("bp%0d_sign", c), 32'(out_sign), 32'd0);
        end
        in_valid = 1'b0;
        consume();

        // Reset during cancellation shifting aborts with no result
        @(negedge clk);
        in_sign = 1'b1; in_exp = 8'h85; in_mant = 25'h0000100; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_exp", 32'(out_exp), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        apply(1'b0, 8'h80, 25'h0800000, lat);
        chk("recover_latency", 32'(lat), 32'd1);
        chk("recover_exp", 32'(out_exp), 32'h80);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
